// File: rtl/counter_sched_pkg.sv
// Shared types for the counter command scheduler: opcodes, FSM states and default width.
package counter_sched_pkg;

  localparam int unsigned CTR_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_READ = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/counter_sched_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, priority pointer moves past each accepted grant.
module rr_arbiter2
  import counter_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // A grant to requester 0 hands priority to 1, and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (advance && (|grant)) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Arbitrates LOAD/UP/DOWN/READ commands from two requesters onto an external up/down counter.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = CTR_WIDTH_DEFAULT,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*NUM_REQ-1:0]   req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_arg,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [WIDTH-1:0]       rsp_count,
  output logic                   busy,
  output logic                   ctr_load,
  output logic                   ctr_enable,
  output logic                   ctr_up_down,
  output logic [WIDTH-1:0]       ctr_d_in,
  input  logic [WIDTH-1:0]       ctr_count
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             id_q, id_d;

  logic             idle;
  logic [1:0]       grant;
  logic             accept;
  logic             acc_id;
  op_e              acc_op;
  logic [WIDTH-1:0] acc_arg;

  assign idle = (state_q == S_IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid & {NUM_REQ{idle}}),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & req_ready);
  assign acc_id    = req_ready[1];
  assign acc_op    = op_e'(acc_id ? req_op[3:2] : req_op[1:0]);
  assign acc_arg   = acc_id ? req_arg[2*WIDTH-1:WIDTH] : req_arg[WIDTH-1:0];
  assign busy      = !idle;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    id_d        = id_q;
    rem_d       = rem_q;
    rsp_valid   = 1'b0;
    rsp_id      = 1'b0;
    rsp_count   = '0;
    ctr_load    = 1'b0;
    ctr_enable  = 1'b0;
    ctr_up_down = 1'b0;
    ctr_d_in    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = acc_op;
          arg_d = acc_arg;
          id_d  = acc_id;
          unique case (acc_op)
            OP_LOAD: state_d = S_LOAD;
            OP_UP, OP_DOWN: begin
              if (acc_arg != '0) begin
                rem_d   = acc_arg;
                state_d = S_RUN;
              end else begin
                state_d = S_RESP;
              end
            end
            default: state_d = S_RESP;
          endcase
        end
      end
      S_LOAD: begin
        ctr_load = 1'b1;
        ctr_d_in = arg_q;
        state_d  = S_RESP;
      end
      S_RUN: begin
        // One counter step per cycle; leave after the last of arg steps.
        ctr_enable  = 1'b1;
        ctr_up_down = (op_q == OP_UP);
        rem_d       = rem_q - 1'b1;
        if (rem_q == WIDTH'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_count = ctr_count;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      arg_q   <= '0;
      id_q    <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
    end
  end

endmodule
